// File: rtl/uart_cmd_sequencer.sv
// Host-side byte-command UART sequencer: frames a payload (FF, data, FE, 7F, gap, 7E) and collects readback.
// Optional macro SEQ_CHECKSUM_EN adds an XOR checksum output (rd_xor) over the accepted readback bytes.
module uart_cmd_sequencer #(
    parameter int unsigned       LEN_W      = 9,
    parameter int unsigned       GAP_CYCLES = 1000,
    parameter int unsigned       TMO_W      = 24,
    parameter logic [TMO_W-1:0]  RX_TIMEOUT = TMO_W'(24'd10000000)
) (
    input  logic             clk_100,
    input  logic             Reset_n,
    input  logic             start,
    input  logic [LEN_W-1:0] payload_len,
    input  logic [LEN_W-1:0] rx_expect,
    input  logic [7:0]       pl_byte,
    input  logic             pl_valid,
    output logic             pl_rd,
    input  logic             tx_busy,
    output logic             tx_en,
    output logic [7:0]       tx_byte,
    input  logic             rx_ready,
    input  logic [7:0]       rx_byte,
    output logic [7:0]       rd_byte,
    output logic             rd_valid,
    output logic [LEN_W-1:0] rd_count,
`ifdef SEQ_CHECKSUM_EN
    output logic [7:0]       rd_xor,
`endif
    output logic             busy,
    output logic             done,
    output logic             err_illegal,
    output logic             err_timeout
);

    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [3:0] {
        IDLE, S_START, S_DATA, S_STOP, S_WRITE, GAP, S_TX, RECV, FIN
    } state_t;

    typedef enum logic [1:0] {PH_ISSUE, PH_HOLD, PH_WAIT} phase_t;

    state_t             state_q, state_d;
    phase_t             ph_q, ph_d;
    logic               hold_q, hold_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic [LEN_W-1:0]   rx_exp_q, rx_exp_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               tx_en_q, tx_en_d;
    logic               pl_rd_q, pl_rd_d;
    logic [7:0]         tx_byte_q, tx_byte_d;
    logic [7:0]         rd_byte_q, rd_byte_d;
    logic               rd_valid_q, rd_valid_d;
    logic [LEN_W-1:0]   rd_count_q, rd_count_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_ill_q, err_ill_d;
    logic               err_tmo_q, err_tmo_d;
    logic [7:0]         xor_q, xor_d;

    logic [7:0]         snd_byte;
    state_t             snd_next;
    logic               is_send;
    logic               pl_illegal;
    logic [LEN_W-1:0]   cnt_inc;

    assign pl_illegal = (pl_byte[7:1] == 7'h7F);
    assign cnt_inc    = (rd_count_q == '1) ? rd_count_q : rd_count_q + LEN_W'(1);
    assign is_send    = (state_q inside {S_START, S_DATA, S_STOP, S_WRITE, S_TX});

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        ph_d       = ph_q;
        hold_d     = hold_q;
        rem_d      = rem_q;
        rx_exp_d   = rx_exp_q;
        gap_d      = gap_q;
        tmo_d      = tmo_q;
        tx_en_d    = 1'b0;
        pl_rd_d    = 1'b0;
        tx_byte_d  = tx_byte_q;
        rd_byte_d  = rd_byte_q;
        rd_valid_d = 1'b0;
        rd_count_d = rd_count_q;
        done_d     = 1'b0;
        err_ill_d  = err_ill_q;
        err_tmo_d  = err_tmo_q;
        xor_d      = xor_q;
        snd_byte   = 8'h00;
        snd_next   = IDLE;

        case (state_q)
            IDLE: begin
                if (start) begin
                    rem_d      = payload_len;
                    rx_exp_d   = rx_expect;
                    err_ill_d  = 1'b0;
                    err_tmo_d  = 1'b0;
                    rd_count_d = '0;
                    xor_d      = 8'h00;
                    ph_d       = PH_ISSUE;
                    state_d    = S_START;
                end
            end
            S_START: begin
                snd_byte = 8'hFF;
                snd_next = (rem_q == '0) ? S_STOP : S_DATA;
            end
            S_DATA: begin
                snd_byte = pl_byte;
                snd_next = (rem_q == '0) ? S_STOP : S_DATA;
            end
            S_STOP: begin
                snd_byte = 8'hFE;
                snd_next = err_ill_q ? FIN : S_WRITE;
            end
            S_WRITE: begin
                snd_byte = 8'h7F;
                snd_next = GAP;
            end
            GAP: begin
                // Status byte emitted by the receiver at end of write is deliberately dropped here
                if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
                    ph_d    = PH_ISSUE;
                    state_d = S_TX;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            S_TX: begin
                snd_byte = 8'h7E;
                snd_next = (rx_exp_q == '0) ? FIN : RECV;
            end
            RECV: begin
                // A byte landing on the timeout cycle wins over the timeout
                if (rx_ready) begin
                    rd_byte_d  = rx_byte;
                    rd_valid_d = 1'b1;
                    rd_count_d = cnt_inc;
                    xor_d      = xor_q ^ rx_byte;
                    tmo_d      = '0;
                    if (cnt_inc == rx_exp_q) begin
                        state_d = FIN;
                    end
                end else if (tmo_q == RX_TIMEOUT) begin
                    err_tmo_d = 1'b1;
                    state_d   = FIN;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            FIN: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Shared ISSUE / HOLD / WAIT handshake toward the UART transmitter
        if (is_send) begin
            case (ph_q)
                PH_ISSUE: begin
                    if (state_q == S_DATA && pl_valid && pl_illegal) begin
                        err_ill_d = 1'b1;
                        state_d   = S_STOP;
                    end else if (!tx_busy && (state_q != S_DATA || pl_valid)) begin
                        tx_en_d   = 1'b1;
                        tx_byte_d = snd_byte;
                        hold_d    = 1'b0;
                        ph_d      = PH_HOLD;
                        if (state_q == S_DATA) begin
                            pl_rd_d = 1'b1;
                            rem_d   = rem_q - LEN_W'(1);
                        end
                    end
                end
                PH_HOLD: begin
                    hold_d = 1'b1;
                    if (hold_q) begin
                        ph_d = PH_WAIT;
                    end
                end
                PH_WAIT: begin
                    if (!tx_busy) begin
                        ph_d    = PH_ISSUE;
                        gap_d   = '0;
                        tmo_d   = '0;
                        state_d = snd_next;
                    end
                end
                default: ph_d = PH_ISSUE;
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    // State and output registers
    always_ff @(posedge clk_100 or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= IDLE;
            ph_q       <= PH_ISSUE;
            hold_q     <= 1'b0;
            rem_q      <= '0;
            rx_exp_q   <= '0;
            gap_q      <= '0;
            tmo_q      <= '0;
            tx_en_q    <= 1'b0;
            pl_rd_q    <= 1'b0;
            tx_byte_q  <= 8'h00;
            rd_byte_q  <= 8'h00;
            rd_valid_q <= 1'b0;
            rd_count_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_ill_q  <= 1'b0;
            err_tmo_q  <= 1'b0;
            xor_q      <= 8'h00;
        end else begin
            state_q    <= state_d;
            ph_q       <= ph_d;
            hold_q     <= hold_d;
            rem_q      <= rem_d;
            rx_exp_q   <= rx_exp_d;
            gap_q      <= gap_d;
            tmo_q      <= tmo_d;
            tx_en_q    <= tx_en_d;
            pl_rd_q    <= pl_rd_d;
            tx_byte_q  <= tx_byte_d;
            rd_byte_q  <= rd_byte_d;
            rd_valid_q <= rd_valid_d;
            rd_count_q <= rd_count_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_ill_q  <= err_ill_d;
            err_tmo_q  <= err_tmo_d;
            xor_q      <= xor_d;
        end
    end

    assign tx_en       = tx_en_q;
    assign pl_rd       = pl_rd_q;
    assign tx_byte     = tx_byte_q;
    assign rd_byte     = rd_byte_q;
    assign rd_valid    = rd_valid_q;
    assign rd_count    = rd_count_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err_illegal = err_ill_q;
    assign err_timeout = err_tmo_q;

`ifdef SEQ_CHECKSUM_EN
    assign rd_xor = xor_q;
`else
    logic unused_xor;
    assign unused_xor = ^xor_q;
`endif

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Directed bench for uart_cmd_sequencer with a 10-cycle UART TX model and scripted readback bytes.
module tb_uart_cmd_sequencer;

    localparam int unsigned      LEN_W = 9;
    localparam int unsigned      GAP   = 20;
    localparam int unsigned      TMO_W = 24;
    localparam logic [TMO_W-1:0] TMO   = 24'd200;

    logic             clk_100 = 1'b0;
    logic             Reset_n;
    logic             start;
    logic [LEN_W-1:0] payload_len;
    logic [LEN_W-1:0] rx_expect;
    logic [7:0]       pl_byte;
    logic             pl_valid;
    logic             pl_rd;
    logic             tx_busy;
    logic             tx_en;
    logic [7:0]       tx_byte;
    logic             rx_ready;
    logic [7:0]       rx_byte;
    logic [7:0]       rd_byte;
    logic             rd_valid;
    logic [LEN_W-1:0] rd_count;
    logic             busy;
    logic             done;
    logic             err_illegal;
    logic             err_timeout;
`ifdef SEQ_CHECKSUM_EN
    logic [7:0]       rd_xor;
`endif

    uart_cmd_sequencer #(
        .LEN_W(LEN_W), .GAP_CYCLES(GAP), .TMO_W(TMO_W), .RX_TIMEOUT(TMO)
    ) dut (
        .clk_100(clk_100), .Reset_n(Reset_n), .start(start),
        .payload_len(payload_len), .rx_expect(rx_expect),
        .pl_byte(pl_byte), .pl_valid(pl_valid), .pl_rd(pl_rd),
        .tx_busy(tx_busy), .tx_en(tx_en), .tx_byte(tx_byte),
        .rx_ready(rx_ready), .rx_byte(rx_byte),
        .rd_byte(rd_byte), .rd_valid(rd_valid), .rd_count(rd_count),
`ifdef SEQ_CHECKSUM_EN
        .rd_xor(rd_xor),
`endif
        .busy(busy), .done(done),
        .err_illegal(err_illegal), .err_timeout(err_timeout)
    );

    always #5 clk_100 = ~clk_100;

    typedef struct {
        int          n_pl;
        logic [31:0] pl;      // byte i at [8*i +: 8]
        int          rx_exp;
        int          n_rx;
        logic [31:0] rx;
        int          n_tx;
        logic [63:0] tx;
        int          plrd;
        int          cnt;
        logic        ill;
        logic        tmo;
        logic [7:0]  xr;
    } vec_t;

    int checks = 0;
    int errors = 0;

    int          cyc = 0;
    int          busy_cnt = 0;
    logic [7:0]  last_tx = 8'h00;
    int          t7e = -1;
    int          t7f_done = -1;
    logic [7:0]  tx_log[$];
    logic [7:0]  rd_log[$];
    int          plrd_cnt = 0;
    int          done_cnt = 0;
    logic [31:0] pl_arr = 32'h0;
    int          pl_n = 0;
    int          pl_idx = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic pl_update();
        pl_valid = (pl_idx < pl_n);
        pl_byte  = pl_valid ? pl_arr[8*pl_idx +: 8] : 8'h00;
    endtask

    // One clock: sample DUT just after the edge and advance TX, payload and monitor models
    task automatic tick();
        @(posedge clk_100);
        #1;
        cyc++;
        if (tx_en) begin
            tx_log.push_back(tx_byte);
            if (tx_byte == 8'h7E) t7e = cyc;
            last_tx  = tx_byte;
            busy_cnt = 10;
            tx_busy  = 1'b1;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) begin
                tx_busy = 1'b0;
                if (last_tx == 8'h7F) t7f_done = cyc;
            end
        end
        if (pl_rd) begin
            plrd_cnt++;
            pl_idx++;
        end
        pl_update();
        if (rd_valid) rd_log.push_back(rd_byte);
        if (done) done_cnt++;
    endtask

    task automatic clear_models(input logic [31:0] pl, input int n);
        tx_log.delete();
        rd_log.delete();
        plrd_cnt = 0;
        done_cnt = 0;
        t7e      = -1;
        t7f_done = -1;
        pl_arr   = pl;
        pl_n     = n;
        pl_idx   = 0;
        pl_update();
    endtask

    task automatic run_seq(input vec_t v, input bit extra_start, input string tag);
        int n;
        int rx_i;
        bit inj;
        logic [63:0] txv;
        logic [31:0] rxv;
        clear_models(v.pl, v.n_pl);
        payload_len = LEN_W'(v.n_pl);
        rx_expect   = LEN_W'(v.rx_exp);
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0; rx_i = 0; inj = 1'b0;
        rxv = v.rx;
        while (done_cnt == 0 && n < 4000) begin
            tick();
            n++;
            rx_ready = 1'b0;
            start    = 1'b0;
            if (extra_start && n == 8) begin
                payload_len = '0;
                rx_expect   = '0;
                start       = 1'b1;
            end
            if (t7f_done >= 0 && !inj && cyc == t7f_done + 5) begin
                rx_ready = 1'b1;
                rx_byte  = 8'hEE;
                inj      = 1'b1;
            end else if (t7e >= 0 && rx_i < v.n_rx && cyc >= t7e + 15 + 6*rx_i) begin
                rx_ready = 1'b1;
                rx_byte  = rxv[8*rx_i +: 8];
                rx_i++;
            end
        end
        rx_ready = 1'b0;
        start    = 1'b0;
        chk({tag, " done_seen"}, 64'(done_cnt), 64'd1);
        chk({tag, " busy_at_done"}, 64'(busy), 64'd0);
        chk({tag, " err_illegal"}, 64'(err_illegal), 64'(v.ill));
        chk({tag, " err_timeout"}, 64'(err_timeout), 64'(v.tmo));
        chk({tag, " rd_count"}, 64'(rd_count), 64'(v.cnt));
`ifdef SEQ_CHECKSUM_EN
        chk({tag, " rd_xor"}, 64'(rd_xor), 64'(v.xr));
`endif
        repeat (4) tick();
        chk({tag, " done_once"}, 64'(done_cnt), 64'd1);
        chk({tag, " tx_count"}, 64'(tx_log.size()), 64'(v.n_tx));
        txv = v.tx;
        for (int i = 0; i < v.n_tx && i < tx_log.size(); i++)
            chk($sformatf("%s tx_byte[%0d]", tag, i), 64'(tx_log[i]), 64'(txv[8*i +: 8]));
        chk({tag, " pl_rd_pulses"}, 64'(plrd_cnt), 64'(v.plrd));
        chk({tag, " rd_valid_pulses"}, 64'(rd_log.size()), 64'(v.cnt));
        for (int i = 0; i < v.cnt && i < rd_log.size(); i++)
            chk($sformatf("%s rd_byte[%0d]", tag, i), 64'(rd_log[i]), 64'(rxv[8*i +: 8]));
        if (!v.ill)
            chk({tag, " gap_ok"}, 64'((t7f_done >= 0 && t7e - t7f_done >= int'(GAP)) ? 1 : 0), 64'd1);
    endtask

    function automatic vec_t mk(input int n_pl, input logic [31:0] pl, input int rx_exp,
                                input int n_rx, input logic [31:0] rx, input int n_tx,
                                input logic [63:0] tx, input int plrd, input int cnt,
                                input logic ill, input logic tmo, input logic [7:0] xr);
        vec_t v;
        v.n_pl = n_pl; v.pl = pl; v.rx_exp = rx_exp; v.n_rx = n_rx; v.rx = rx;
        v.n_tx = n_tx; v.tx = tx; v.plrd = plrd; v.cnt = cnt;
        v.ill = ill; v.tmo = tmo; v.xr = xr;
        return v;
    endfunction

    vec_t vecs[4];

    initial begin
        Reset_n = 1'b0; start = 1'b0; payload_len = '0; rx_expect = '0;
        pl_byte = 8'h00; pl_valid = 1'b0; tx_busy = 1'b0; rx_ready = 1'b0; rx_byte = 8'h00;

        vecs[0] = mk(3, 32'h00030201, 3, 3, 32'h003C5AA5, 7, 64'h007E7FFE030201FF, 3, 3, 1'b0, 1'b0, 8'hC3);
        vecs[1] = mk(0, 32'h0,        0, 0, 32'h0,        4, 64'h000000007E7FFEFF, 0, 0, 1'b0, 1'b0, 8'h00);
        vecs[2] = mk(3, 32'h0020FE10, 2, 0, 32'h0,        3, 64'h0000000000FE10FF, 1, 0, 1'b1, 1'b0, 8'h00);
        vecs[3] = mk(1, 32'h00000055, 4, 2, 32'h00002211, 5, 64'h0000007E7FFE55FF, 1, 2, 1'b0, 1'b1, 8'h33);

        repeat (3) tick();
        chk("reset_outputs", {busy, tx_en, done, pl_rd, rd_valid, err_illegal, err_timeout,
                              tx_byte, rd_byte, 7'(rd_count)}, 64'd0);
        chk("reset_rd_count", 64'(rd_count), 64'd0);
        Reset_n = 1'b1;
        repeat (2) tick();

        for (int k = 0; k < 4; k++)
            run_seq(vecs[k], 1'b0, $sformatf("vec%0d", k));

        // Asynchronous reset while waiting in GAP abandons the sequence
        begin
            int n;
            clear_models(32'h00030201, 3);
            payload_len = 9'd3;
            rx_expect   = 9'd3;
            start = 1'b1;
            tick();
            start = 1'b0;
            n = 0;
            while (!(t7f_done >= 0 && cyc >= t7f_done + 8) && n < 2000) begin
                tick();
                n++;
            end
            chk("gap_reached", 64'(t7f_done >= 0), 64'd1);
            chk("busy_in_gap", 64'(busy), 64'd1);
            #1;
            Reset_n = 1'b0;
            #1;
            chk("async_reset_outputs", {busy, tx_en, done, pl_rd, rd_valid, err_illegal, err_timeout,
                                        tx_byte, rd_byte, 7'(rd_count)}, 64'd0);
            chk("async_reset_tx_byte", 64'(tx_byte), 64'd0);
            repeat (2) tick();
            Reset_n = 1'b1;
            repeat (5) tick();
            chk("no_done_after_reset", 64'(done_cnt), 64'd0);
        end

        run_seq(vecs[0], 1'b1, "post_reset_busy_start");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
